// File: rtl/mem_arbiter.sv
// Shares one memory4c port between I- and D-side cache controllers: 8-word block fills and D-side single-word writes.
// Define ROUND_ROBIN_EN for alternating priority on contested requests; otherwise D beats I.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_grant,
  output logic              d_grant,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              i_done,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  localparam int CW = $clog2(BLOCK_WORDS) + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BLOCK_WORDS * 2 - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              own_d_q, own_d_d;   // 1 = D side owns the transaction
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     k_q, k_d;
  logic [CW-1:0]     r_q, r_d;
  logic [ADDR_W-1:0] faddr_q;
  logic [DATA_W-1:0] fdata_q;
  logic              pick_d;
  logic              fill_hit;
`ifdef ROUND_ROBIN_EN
  logic              rr_q, rr_d;         // 1 = D has priority
`endif

  assign fill_hit = (state_q == FILL) && mem_data_valid;

  always_comb begin
    state_d      = state_q;
    own_d_d      = own_d_q;
    wr_d         = wr_q;
    base_d       = base_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    k_d          = k_q;
    r_d          = r_q;
    i_grant      = 1'b0;
    d_grant      = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    mem_addr     = '0;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = '0;
`ifdef ROUND_ROBIN_EN
    rr_d         = rr_q;
    pick_d       = d_req && (!i_req || rr_q);
`else
    pick_d       = d_req;
`endif

    case (state_q)
      IDLE: begin
        if (d_req || i_req) begin
          own_d_d = pick_d;
          wr_d    = pick_d && d_wr;
          base_d  = (pick_d ? d_addr : i_addr) & ~LINE_MASK;
          waddr_d = d_addr;
          wdata_d = d_wdata;
          k_d     = '0;
          r_d     = '0;
          state_d = (pick_d && d_wr) ? WRITE : FILL;
`ifdef ROUND_ROBIN_EN
          // Pointer moves only on contention, so a lone requester never shifts priority.
          if (d_req && i_req) rr_d = !pick_d;
`endif
        end
      end
      FILL: begin
        i_grant = !own_d_q;
        d_grant = own_d_q;
        if (k_q < CW'(BLOCK_WORDS)) begin
          mem_enable = 1'b1;
          mem_addr   = base_q + (ADDR_W'(k_q) << 1);
          k_d        = k_q + 1'b1;
        end
        if (fill_hit) begin
          r_d          = r_q + 1'b1;
          i_fill_valid = !own_d_q;
          d_fill_valid = own_d_q;
          if (r_q == CW'(BLOCK_WORDS - 1)) begin
            i_done  = !own_d_q;
            d_done  = own_d_q;
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        d_grant    = 1'b1;
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = waddr_q;
        mem_wdata  = wdata_q;
        state_d    = DONE;
      end
      DONE: begin
        d_done  = wr_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    fill_addr = fill_hit ? base_q + (ADDR_W'(r_q) << 1) : faddr_q;
    fill_data = fill_hit ? mem_rdata : fdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_d_q <= 1'b0;
      wr_q    <= 1'b0;
      base_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      r_q     <= '0;
      faddr_q <= '0;
      fdata_q <= '0;
`ifdef ROUND_ROBIN_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      own_d_q <= own_d_d;
      wr_q    <= wr_d;
      base_q  <= base_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      r_q     <= r_d;
      faddr_q <= fill_addr;
      fdata_q <= fill_data;
`ifdef ROUND_ROBIN_EN
      rr_q    <= rr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of directed transactions plus reset, contention and back-to-back sequences.
// Memory is modelled as a fixed-latency (L=4) pipelined word array; expected data comes from a separate shadow image.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk, rst;
  logic        i_req, d_req, d_wr;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_grant, d_grant, i_fill_valid, d_fill_valid, i_done, d_done;
  logic [15:0] fill_addr, fill_data, mem_addr, mem_wdata, mem_rdata;
  logic        mem_enable, mem_wr, mem_data_valid;

  mem_arbiter #(.BLOCK_WORDS(8), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .i_grant(i_grant), .d_grant(d_grant),
    .i_fill_valid(i_fill_valid), .d_fill_valid(d_fill_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .i_done(i_done), .d_done(d_done),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]  mem     [0:32767];
  logic [15:0]  exp_mem [0:32767];
  logic [L-1:0] pv = '0;
  logic [15:0]  pa [0:L-1];

  always @(posedge clk) begin
    if (mem_enable && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
    pv    <= {pv[L-2:0], mem_enable && !mem_wr};
    pa[0] <= mem_addr;
    for (int s = 1; s < L; s++) pa[s] <= pa[s-1];
  end
  assign mem_data_valid = pv[L-1];
  assign mem_rdata      = mem[pa[L-1][15:1]];

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (i_grant && d_grant) overlap++;
      if (i_fill_valid && d_fill_valid) overlap++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctrl"}, {24'd0, i_grant, d_grant, i_fill_valid, d_fill_valid,
                         i_done, d_done, mem_enable, mem_wr}, 32'd0);
    chk({tag, "_fill_addr"}, {16'd0, fill_addr}, 32'd0);
    chk({tag, "_fill_data"}, {16'd0, fill_data}, 32'd0);
    chk({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
    chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          drop;      // drop req and change addr right after grant
    int          exp_done;  // cycles from IDLE sample to done pulse
  } vec_t;

  task automatic do_txn(input vec_t v);
    logic [15:0] base;
    int issues, rets, dones, done_n;
    bit other_bad, own_fv, own_done;
    base = v.addr & 16'hFFF0;
    issues = 0; rets = 0; dones = 0; done_n = 0; other_bad = 1'b0;
    @(negedge clk);
    if (v.is_d) begin
      d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
      if (v.wr) exp_mem[v.addr[15:1]] = v.wdata;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
    for (int n = 1; n <= 40; n++) begin
      cyc();
      own_fv   = v.is_d ? d_fill_valid : i_fill_valid;
      own_done = v.is_d ? d_done : i_done;
      if (v.is_d ? (i_grant || i_fill_valid || i_done) : (d_grant || d_fill_valid || d_done))
        other_bad = 1'b1;
      if (n == 1) begin
        chk("grant_first_cycle", {30'd0, i_grant, d_grant}, v.is_d ? 32'd1 : 32'd2);
        if (v.drop) begin
          if (v.is_d) begin d_req = 1'b0; d_addr = 16'h3000; end
          else begin i_req = 1'b0; i_addr = 16'h3000; end
        end
      end
      if (mem_enable && !mem_wr) begin
        chk("issue_addr", {16'd0, mem_addr}, {16'd0, 16'(base + 2 * issues)});
        chk("issue_cycle", n, issues + 1);
        issues++;
      end
      if (mem_enable && mem_wr) begin
        chk("write_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        chk("write_data", {16'd0, mem_wdata}, {16'd0, v.wdata});
        chk("write_cycle", n, 1);
      end
      if (own_fv) begin
        chk("fill_addr", {16'd0, fill_addr}, {16'd0, 16'(base + 2 * rets)});
        chk("fill_data", {16'd0, fill_data}, {16'd0, exp_mem[int'(base[15:1]) + rets]});
        rets++;
      end
      if (own_done) begin
        dones++;
        if (done_n == 0) begin
          done_n = n;
          if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
        end
      end
      if (done_n != 0 && n == done_n + 1)
        chk("post_done_grants", {30'd0, i_grant, d_grant}, 32'd0);
      if (done_n != 0 && n >= done_n + 3) break;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("done_latency", done_n, v.exp_done);
    chk("done_count", dones, 1);
    chk("fill_issues", issues, v.wr ? 0 : 8);
    chk("fill_returns", rets, v.wr ? 0 : 8);
    chk("other_side_quiet", {31'd0, other_bad}, 32'd0);
  endtask

  task automatic wait_done(input bit side_d, input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (side_d ? d_done : i_done) begin ok = 1'b1; break; end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic run_pair(input bit exp_d_first);
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0500;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0600;
    cyc();
    chk("pair_first_grant", {30'd0, i_grant, d_grant}, exp_d_first ? 32'd1 : 32'd2);
    wait_done(exp_d_first, "pair_first_done");
    if (exp_d_first) d_req = 1'b0; else i_req = 1'b0;
    cyc();
    chk("pair_done_grants", {30'd0, i_grant, d_grant}, 32'd0);
    cyc();
    chk("pair_idle_grants", {30'd0, i_grant, d_grant}, 32'd0);
    cyc();
    chk("pair_second_grant", {30'd0, i_grant, d_grant}, exp_d_first ? 32'd2 : 32'd1);
    wait_done(!exp_d_first, "pair_second_done");
    i_req = 1'b0; d_req = 1'b0;
    cyc();
  endtask

  vec_t vecs [7];
  int   cnt, stray;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i]     = 16'(i * 37 + 16'h1357);
      exp_mem[i] = 16'(i * 37 + 16'h1357);
    end
    vecs[0] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h1236, wdata: 16'h0000, drop: 1'b0, exp_done: 12};
    vecs[1] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0044, wdata: 16'hBEEF, drop: 1'b0, exp_done: 2};
    vecs[2] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0040, wdata: 16'h0000, drop: 1'b0, exp_done: 12};
    vecs[3] = '{is_d: 1'b1, wr: 1'b0, addr: 16'hFFFE, wdata: 16'h0000, drop: 1'b0, exp_done: 12};
    vecs[4] = '{is_d: 1'b1, wr: 1'b1, addr: 16'h0001, wdata: 16'h1234, drop: 1'b0, exp_done: 2};
    vecs[5] = '{is_d: 1'b1, wr: 1'b0, addr: 16'h0000, wdata: 16'h0000, drop: 1'b0, exp_done: 12};
    vecs[6] = '{is_d: 1'b0, wr: 1'b0, addr: 16'h0206, wdata: 16'h0000, drop: 1'b1, exp_done: 12};

    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int t = 0; t < 7; t++) do_txn(vecs[t]);

    // Reset on the third return of an I fill.
    @(negedge clk);
    i_req = 1'b1; i_addr = 16'h0100;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (i_fill_valid) cnt++;
      if (cnt == 3) break;
    end
    chk("rst_third_return", cnt, 3);
    rst = 1'b1;
    #1;
    chk_quiet("midfill_reset");
    i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int n = 0; n < 8; n++) begin
      cyc();
      if (i_fill_valid || d_fill_valid || i_done || d_done || i_grant || d_grant) stray++;
    end
    chk("late_returns_ignored", stray, 0);
    do_txn('{is_d: 1'b0, wr: 1'b0, addr: 16'h0108, wdata: 16'h0000, drop: 1'b0, exp_done: 12});

    run_pair(1'b1);

    // D request held through its done: DONE and IDLE cycles precede the second grant.
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
    wait_done(1'b1, "b2b_first_done");
    cyc();
    chk("b2b_done_grants", {30'd0, i_grant, d_grant}, 32'd0);
    cyc();
    chk("b2b_idle_grants", {30'd0, i_grant, d_grant}, 32'd0);
    cyc();
    chk("b2b_second_grant", {30'd0, i_grant, d_grant}, 32'd1);
    d_req = 1'b0;
    wait_done(1'b1, "b2b_second_done");
    cyc();

`ifdef ROUND_ROBIN_EN
    run_pair(1'b0);
`else
    run_pair(1'b1);
`endif

    chk("exclusive_grants_and_fills", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
